// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module      : alu_pkg
// Description : Opcodes, FSM state encoding and helpers shared by alu_seq.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_XOR  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_MUL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_DIVU = 4'd10,
    ALU_REMU = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] ctl);
    return (ctl == ALU_MUL) || (ctl == ALU_DIVU) || (ctl == ALU_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter.sv
//------------------------------------------------------------------------------
// Module      : alu_iter
// Description : Iterative engine: shift-add multiply, restoring divide/remainder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_mul;
  logic             r_rem;
  logic [WIDTH-1:0] r_x;    // multiplicand (MUL) or divisor (DIV/REM)
  logic [WIDTH-1:0] r_y;    // multiplier (MUL) or dividend/quotient (DIV/REM)
  logic [WIDTH-1:0] r_acc;  // product (MUL) or partial remainder (DIV/REM)

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_rem_sh = {r_acc, r_y[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_x};
  assign w_ge     = ~w_diff[WIDTH];

  always_comb begin
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_acc_nxt = r_acc;
    if (r_mul) begin
      w_acc_nxt = r_y[0] ? (r_acc + r_x) : r_acc;
      w_x_nxt   = {r_x[WIDTH-2:0], 1'b0};
      w_y_nxt   = {1'b0, r_y[WIDTH-1:1]};
    end else begin
      // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
      w_acc_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
      w_y_nxt   = {r_y[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_mul <= 1'b0;
      r_rem <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(WIDTH);
      r_mul <= (i_op == ALU_MUL);
      r_rem <= (i_op == ALU_REMU);
      r_x   <= (i_op == ALU_MUL) ? i_a : i_b;
      r_y   <= (i_op == ALU_MUL) ? i_b : i_a;
      r_acc <= '0;
    end else if (o_busy) begin
      r_cnt <= r_cnt - 1'b1;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_acc <= w_acc_nxt;
    end
  end

  assign o_busy   = (r_cnt != '0);
  assign o_done   = o_busy && (r_cnt == CNT_W'(1));
  assign o_result = (r_mul || r_rem) ? w_acc_nxt : w_y_nxt;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// Module      : alu_seq
// Description : Handshaked EX-stage ALU with fast ops and iterative MUL/DIVU/REMU.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [CTL_W-1:0] ctl_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic             illegal_o
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_res;
  logic             r_illegal;

  logic [3:0]       w_ctl;
  logic             w_ctl_hi;
  logic             w_mc;
  logic             w_in_ready;
  logic             w_accept;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_fast_res;
  logic             w_fast_ill;
  logic             w_iter_busy;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_res;

  // Opcode bits above the defined encoding make the request illegal.
  if (CTL_W > ALU_OP_W) begin : g_ctl_wide
    assign w_ctl    = ctl_i[3:0];
    assign w_ctl_hi = |ctl_i[CTL_W-1:ALU_OP_W];
  end else begin : g_ctl_narrow
    assign w_ctl    = 4'(ctl_i);
    assign w_ctl_hi = 1'b0;
  end

  assign w_mc       = !w_ctl_hi && is_multicycle(w_ctl);
  assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready_i);
  assign w_accept   = in_valid_i && w_in_ready;
  assign w_sh       = op2_i[SH_W-1:0];

  always_comb begin
    w_fast_res = '0;
    w_fast_ill = 1'b0;
    if (w_ctl_hi) begin
      w_fast_ill = 1'b1;
    end else begin
      case (alu_op_e'(w_ctl))
        ALU_AND: w_fast_res = op1_i & op2_i;
        ALU_XOR: w_fast_res = op1_i ^ op2_i;
        ALU_SLL: w_fast_res = op1_i << w_sh;
        ALU_ADD: w_fast_res = op1_i + op2_i;
        ALU_SUB: w_fast_res = op1_i - op2_i;
        ALU_SRA: w_fast_res = $signed(op1_i) >>> w_sh;
        ALU_OR:  w_fast_res = op1_i | op2_i;
        ALU_SRL: w_fast_res = op1_i >> w_sh;
        ALU_SLT: w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
        ALU_MUL, ALU_DIVU, ALU_REMU: w_fast_res = '0;
        default: w_fast_ill = 1'b1;
      endcase
    end
  end

  alu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk_i),
    .rst      (rst_i),
    .i_start  (w_accept && w_mc),
    .i_op     (alu_op_e'(w_ctl)),
    .i_a      (op1_i),
    .i_b      (op2_i),
    .o_busy   (w_iter_busy),
    .o_done   (w_iter_done),
    .o_result (w_iter_res)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_mc ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (w_iter_done)      w_state_nxt = ST_DONE;
        else if (!w_iter_busy) w_state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        if (out_ready_i) begin
          if (w_accept) w_state_nxt = w_mc ? ST_BUSY : ST_DONE;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res     <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_mc) begin
      r_res     <= w_fast_res;
      r_illegal <= w_fast_ill;
    end else if ((r_state == ST_BUSY) && w_iter_done) begin
      r_res     <= w_iter_res;
      r_illegal <= 1'b0;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = (r_state == ST_DONE);
  assign res_o       = r_res;
  assign illegal_o   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq against an arithmetic reference.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ctl;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .CTL_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .ctl_i       (ctl),
    .op1_i       (op1),
    .op2_i       (op2),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res),
    .illegal_o   (illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic il);
    logic [4:0] sh;
    sh = b[4:0];
    r  = '0;
    il = 1'b0;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a ^ b;
      4'd2:  r = a << sh;
      4'd3:  r = a + b;
      4'd4:  r = a - b;
      4'd5:  r = a * b;
      4'd6:  r = $signed(a) >>> sh;
      4'd7:  r = a | b;
      4'd8:  r = a >> sh;
      4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: r = (b == 0) ? a : a % b;
      default: il = 1'b1;
    endcase
  endfunction

  // Issue one request from IDLE with out_ready high; returns result and edges-after-accept.
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic il, output int lat);
    in_valid = 1'b1; ctl = c; op1 = a; op2 = b; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    r  = res;
    il = illegal;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ctl = '0; op1 = '0; op2 = '0;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || res !== '0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset: valid=%b res=%h ill=%b rdy=%b, want 0 0 0 1", out_valid, res, illegal, in_ready);
      n_fail++;
    end
  endtask

  task automatic test_fast_directed();
    logic [3:0]   tc [7] = '{4'd3, 4'd4, 4'd6, 4'd8, 4'd2, 4'd9, 4'd7};
    logic [W-1:0] ta [7] = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'h0F00};
    logic [W-1:0] tb [7] = '{32'h1, 32'h1, 32'h24, 32'h24, 32'd31, 32'h1, 32'h00F0};
    logic [W-1:0] te [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h1, 32'h0FF0};
    logic [W-1:0] r;
    logic il;
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(tc[i], ta[i], tb[i], r, il, lat);
      n_tests++;
      if (r !== te[i] || il !== 1'b0 || lat != 0) begin
        $display("FAIL fast_op%0d ctl=%0d: res=%h ill=%b lat=%0d, want %h 0 0", i, tc[i], r, il, lat, te[i]);
        n_fail++;
      end
      n_tests++;
      if (out_valid !== 1'b0) begin
        $display("FAIL fast_single_valid%0d: valid=%b, want 0", i, out_valid);
        n_fail++;
      end
    end
  endtask

  task automatic test_mul_busy();
    int bad = 0;
    in_valid = 1'b1; ctl = 4'd5; op1 = 32'hFFFF_FFFD; op2 = 32'd7; out_ready = 1'b1;
    tick();
    ctl = 4'd3;
    for (int i = 0; i < 32; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      in_valid = i[0];
      op1 = $urandom; op2 = $urandom;
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (bad != 0) begin
      $display("FAIL mul_busy_flags: bad cycles=%0d, want 0", bad);
      n_fail++;
    end
    n_tests++;
    if (out_valid !== 1'b1 || res !== 32'hFFFF_FFEB || illegal !== 1'b0) begin
      $display("FAIL mul_result: valid=%b res=%h ill=%b, want 1 ffffffeb 0", out_valid, res, illegal);
      n_fail++;
    end
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      $display("FAIL mul_ignored_pulses: extra valid cycles=%0d, want 0", bad);
      n_fail++;
    end
  endtask

  task automatic test_div();
    logic [3:0]   tc [4] = '{4'd10, 4'd11, 4'd10, 4'd11};
    logic [W-1:0] ta [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [W-1:0] tb [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] te [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    logic [W-1:0] r;
    logic il;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(tc[i], ta[i], tb[i], r, il, lat);
      n_tests++;
      if (r !== te[i] || il !== 1'b0 || lat != 32) begin
        $display("FAIL div%0d ctl=%0d: res=%h ill=%b lat=%0d, want %h 0 32", i, tc[i], r, il, lat, te[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_backpressure_back_to_back();
    logic [W-1:0] a [3];
    logic [W-1:0] b [3];
    int bad = 0;
    in_valid = 1'b1; ctl = 4'd1; op1 = 32'hF0F0_F0F0; op2 = 32'hFFFF_0000; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || res !== 32'h0F0F_F0F0 || in_ready !== 1'b0) bad++;
      in_valid = i[0]; ctl = 4'd3; op1 = $urandom; op2 = $urandom;
      tick();
    end
    n_tests++;
    if (bad != 0 || res !== 32'h0F0F_F0F0) begin
      $display("FAIL backpressure_hold: bad cycles=%0d res=%h, want 0 0f0ff0f0", bad, res);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom; b[i] = $urandom;
    end
    out_ready = 1'b1;
    in_valid = 1'b1; ctl = 4'd0; op1 = a[0]; op2 = b[0];
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL ready_passthrough: rdy=%b, want 1", in_ready);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) begin
        op1 = a[i+1]; op2 = b[i+1];
      end else begin
        in_valid = 1'b0;
      end
      n_tests++;
      if (out_valid !== 1'b1 || res !== (a[i] & b[i])) begin
        $display("FAIL back_to_back%0d: valid=%b res=%h, want 1 %h", i, out_valid, res, a[i] & b[i]);
        n_fail++;
      end
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      $display("FAIL back_to_back_end: valid=%b, want 0", out_valid);
      n_fail++;
    end
  endtask

  task automatic test_reset_busy();
    int seen = 0;
    logic [W-1:0] r;
    logic il;
    int lat;
    in_valid = 1'b1; ctl = 4'd10; op1 = 32'd1000; op2 = 32'd3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_busy: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
      n_fail++;
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin
      $display("FAIL reset_busy_discard: valid cycles=%0d, want 0", seen);
      n_fail++;
    end
    do_op(4'd3, 32'd2, 32'd3, r, il, lat);
    n_tests++;
    if (r !== 32'd5 || lat != 0) begin
      $display("FAIL after_reset_add: res=%h lat=%0d, want 5 0", r, lat);
      n_fail++;
    end
  endtask

  task automatic test_reset_accept();
    in_valid = 1'b1; ctl = 4'd3; op1 = 32'd9; op2 = 32'd9; out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || res !== '0) begin
      $display("FAIL reset_accept: valid=%b res=%h, want 0 0", out_valid, res);
      n_fail++;
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_accept_late: valid=%b, want 0", out_valid);
      n_fail++;
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] r;
    logic il;
    int lat;
    do_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, r, il, lat);
    n_tests++;
    if (r !== '0 || il !== 1'b1 || lat != 0) begin
      $display("FAIL illegal13: res=%h ill=%b lat=%0d, want 0 1 0", r, il, lat);
      n_fail++;
    end
    do_op(4'd15, $urandom, $urandom, r, il, lat);
    n_tests++;
    if (r !== '0 || il !== 1'b1 || lat != 0) begin
      $display("FAIL illegal15: res=%h ill=%b lat=%0d, want 0 1 0", r, il, lat);
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic [3:0]   c;
    logic [W-1:0] a, b, r, er;
    logic il, eil;
    int lat, elat;
    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      model(c, a, b, er, eil);
      elat = (c == 4'd5 || c == 4'd10 || c == 4'd11) ? W : 0;
      do_op(c, a, b, r, il, lat);
      n_tests++;
      if (r !== er || il !== eil || lat != elat) begin
        $display("FAIL random%0d ctl=%0d a=%h b=%h: res=%h ill=%b lat=%0d, want %h %b %0d",
                 i, c, a, b, r, il, lat, er, eil, elat);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fast_directed();
    test_mul_busy();
    test_div();
    test_backpressure_back_to_back();
    test_reset_busy();
    test_reset_accept();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the single-cycle datapath ALU.
- Width is configurable. The opcode set is extended with OR/SRL/SLT, an iterative multiplier and an unsigned divider/remainder.
- Results are registered behind a valid/ready handshake, so the EX stage can stall on multi-cycle ops.
- Sits between the ID/EX pipeline register and the EX/MEM register. The hazard unit stalls on in_ready_o.

Parameters:
- WIDTH, 32, operand and result width; power of two, >= 8.
- CTL_W, 4, opcode width.
- SH_W, $clog2(WIDTH), shift-amount bits taken from op2 (derived; do not override).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  request accepted on an edge where in_valid_i && in_ready_o.
- ctl_i  input  CTL_W  opcode.
- op1_i  input  WIDTH  operand 1, two's complement.
- op2_i  input  WIDTH  operand 2, two's complement.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- res_o  output  WIDTH  result; held stable while out_valid_o && !out_ready_i.
- illegal_o  output  1  qualifies res_o; high when the opcode was unknown.

Behaviour:
- Opcode encoding:
  - 0 AND; 1 XOR; 2 SLL; 3 ADD; 4 SUB; 5 MUL (low WIDTH bits); 6 SRA.
  - 7 OR; 8 SRL; 9 SLT (signed, result 0/1).
  - 10 DIVU; 11 REMU.
  - 12-15 illegal: res=0, illegal_o=1.
- Shifts use op2[SH_W-1:0] only; the upper bits are ignored. SRA replicates op1[WIDTH-1].
- ADD/SUB/MUL wrap modulo 2^WIDTH; there is no overflow flag.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready_o=1. On accept:
    - Fast op (all except 5, 10, 11): compute and register res_o, go to DONE.
    - MUL/DIVU/REMU: latch operands, clear accumulator, load counter with WIDTH, go to BUSY.
  - BUSY: in_ready_o=0. One iteration per cycle, counter decrements. On the edge where the counter reaches 0, register the result and go to DONE.
    - MUL: shift-add, LSB-first on op2.
    - DIVU/REMU: restoring division, MSB-first.
  - DONE: out_valid_o=1.
    - If out_ready_i=0: hold res_o/illegal_o.
    - If out_ready_i=1: in_ready_o=1 (combinational). A simultaneous accept starts the next op directly (fast op -> DONE with the new result; multi-cycle -> BUSY); otherwise go to IDLE.
- Latency, counted from the accept edge A:
  - Fast op: out_valid_o high in the cycle after A.
  - MUL/DIVU/REMU: out_valid_o high after edge A+WIDTH.
  - Back-to-back fast ops with out_ready_i held high sustain 1 result/cycle.
- Divide by zero follows RISC-V: DIVU -> all ones; REMU -> op1. Still takes WIDTH cycles; illegal_o=0.
- Requests are ignored when in_ready_o=0; inputs may change freely in BUSY.
- Reset (any state, including mid-BUSY): next state IDLE; out_valid_o=0, res_o=0, illegal_o=0, counter=0. in_ready_o=1 from the first cycle after reset. An in-flight operation is discarded with no output.
- Simultaneous rst_i and accept: reset wins; the request is dropped.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams/enum (ALU_AND..ALU_REMU).
  - FSM state encoding.
  - Helper function is_multicycle(ctl).
- Sub-module alu_iter holds the iterative MUL/DIVU/REMU engine.
  - Inputs: start, op, a, b.
  - Outputs: busy, done pulse, result.
  - The top keeps the handshake FSM, the fast combinational ops and the output register.

Test Plan:
- ADD 0x7FFFFFFF + 1, out_ready_i=1 -> next cycle res=0x80000000, valid one cycle; SUB 0 - 1 -> 0xFFFFFFFF.
- SRA 0x80000000 by op2=0x24 (amount 4) -> 0xF8000000; SRL same -> 0x08000000; SLL 1 by 31 -> 0x80000000; SLT -1 vs 1 -> 1.
- MUL -3 * 7 -> res=0xFFFFFFEB exactly after edge A+32; in_ready_o=0 throughout BUSY; in_valid_i pulses meanwhile are ignored.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Backpressure: hold out_ready_i=0 for 5 cycles after XOR 0xF0F0F0F0^0xFFFF0000 -> res 0x0F0FF0F0 stable, in_ready_o=0. Then three back-to-back ANDs with out_ready_i=1 -> 3 results in 3 consecutive cycles.
- rst_i asserted at BUSY cycle 10 of a DIVU -> out_valid_o=0 next cycle, no result ever emitted, in_ready_o=1. Opcode 13 -> res=0, illegal_o=1 in the cycle after accept.
